// File: rtl/i2d_pipe_ctrl_pkg.sv
// i2d_pipe_ctrl_pkg
//   Shared encodings for the i2d pipeline controller: decoded ALU op codes,
//   exception cause codes and the sequencer state encoding, plus a helper
//   that classifies the multi-cycle (MUL/DIV family) ops.
package i2d_pipe_ctrl_pkg;

    localparam logic [3:0] I2D_ALUOP_ADD  = 4'h0;
    localparam logic [3:0] I2D_ALUOP_SUB  = 4'h1;
    localparam logic [3:0] I2D_ALUOP_AND  = 4'h2;
    localparam logic [3:0] I2D_ALUOP_OR   = 4'h3;
    localparam logic [3:0] I2D_ALUOP_XOR  = 4'h4;
    localparam logic [3:0] I2D_ALUOP_SHL  = 4'h5;
    localparam logic [3:0] I2D_ALUOP_SHR  = 4'h6;
    localparam logic [3:0] I2D_ALUOP_SAR  = 4'h7;
    localparam logic [3:0] I2D_ALUOP_MUL  = 4'h8;
    localparam logic [3:0] I2D_ALUOP_MULU = 4'h9;
    localparam logic [3:0] I2D_ALUOP_DIV  = 4'hA;
    localparam logic [3:0] I2D_ALUOP_DIVU = 4'hB;
    localparam logic [3:0] I2D_ALUOP_MOV  = 4'hC;
    localparam logic [3:0] I2D_ALUOP_CMP  = 4'hD;

    localparam logic [1:0] I2D_EXC_NONE = 2'b00;
    localparam logic [1:0] I2D_EXC_ILL  = 2'b01;
    localparam logic [1:0] I2D_EXC_SWI  = 2'b10;

    typedef enum logic [1:0] {
        I2D_PCTRL_RUN     = 2'd0,
        I2D_PCTRL_MD_WAIT = 2'd1,
        I2D_PCTRL_FLUSH   = 2'd2
    } pctrl_state_t;

    // True for the ops that occupy EX for several cycles.
    function automatic logic is_muldiv(input logic [3:0] op);
        return (op == I2D_ALUOP_MUL)  || (op == I2D_ALUOP_MULU) ||
               (op == I2D_ALUOP_DIV)  || (op == I2D_ALUOP_DIVU);
    endfunction

endpackage

// File: rtl/i2d_hazard_det.sv
// i2d_hazard_det
//   Combinational load-use comparator: flags when the instruction in ID reads
//   a register that the load currently in EX has not yet written.
//   Ports:
//     rfa_addr/rfa_r  ID read-port A address and read-valid
//     rfb_addr/rfb_r  ID read-port B address and read-valid
//     ex_ld           EX holds a load writing ex_wr_addr
//     ex_wr_addr      EX destination register
//     hazard          load-use conflict this cycle
module i2d_hazard_det (
    input  logic [3:0] rfa_addr,
    input  logic       rfa_r,
    input  logic [3:0] rfb_addr,
    input  logic       rfb_r,
    input  logic       ex_ld,
    input  logic [3:0] ex_wr_addr,
    output logic       hazard
);

    assign hazard = ex_ld & ((rfa_r & (rfa_addr == ex_wr_addr)) |
                             (rfb_r & (rfb_addr == ex_wr_addr)));

endmodule

// File: rtl/i2d_pipe_ctrl.sv
// i2d_pipe_ctrl
//   Pipeline sequencer for the i2d IF/ID/EX stages. Turns decode and EX status
//   into stall, bubble, PC-redirect and exception-capture controls, and owns
//   MUL/DIV occupancy, branch/exception flush and the load-use interlock.
//   Ports:
//     clk, rst                 clock, asynchronous active-high reset
//     alu_op, id_valid, id_err, swi, id_pc   ID instruction status
//     rfa_addr/rfa_r, rfb_addr/rfb_r         ID register reads
//     ex_ld, ex_wr_addr        EX load and its destination
//     ex_br_taken, ex_target   EX taken branch and its target
//     exc_ack                  RFE retired, clears exc_pending
//     if_stall, id_stall, ex_hold            combinational holds
//     id_dis                   registered bubble into ID->EX
//     pc_load, pc_next         registered one-cycle redirect pulse + address
//     epc, exc_cause, exc_pending            captured exception state
module i2d_pipe_ctrl
    import i2d_pipe_ctrl_pkg::*;
#(
    parameter int          MD_CYCLES = 4,
    parameter logic [31:0] VEC_ILL   = 32'h0000_0004,
    parameter logic [31:0] VEC_SWI   = 32'h0000_0008
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [3:0]  alu_op,
    input  logic        id_valid,
    input  logic        id_err,
    input  logic        swi,
    input  logic [31:0] id_pc,
    input  logic [3:0]  rfa_addr,
    input  logic [3:0]  rfb_addr,
    input  logic        rfa_r,
    input  logic        rfb_r,
    input  logic        ex_ld,
    input  logic [3:0]  ex_wr_addr,
    input  logic        ex_br_taken,
    input  logic [31:0] ex_target,
    input  logic        exc_ack,
    output logic        if_stall,
    output logic        id_stall,
    output logic        ex_hold,
    output logic        id_dis,
    output logic        pc_load,
    output logic [31:0] pc_next,
    output logic [31:0] epc,
    output logic [1:0]  exc_cause,
    output logic        exc_pending
);

    pctrl_state_t state;
    logic [3:0]   md_cnt;
    logic         hazard;

    i2d_hazard_det u_hazard_det (
        .rfa_addr   (rfa_addr),
        .rfa_r      (rfa_r),
        .rfb_addr   (rfb_addr),
        .rfb_r      (rfb_r),
        .ex_ld      (ex_ld),
        .ex_wr_addr (ex_wr_addr),
        .hazard     (hazard)
    );

    // Events are only recognised in RUN, in strict priority order. A taken
    // branch makes the ID instruction wrong-path, so it masks everything below.
    logic run, br_ev, ill_ev, swi_ev, md_ev, haz_ev, id_busy;

    assign run     = (state == I2D_PCTRL_RUN);
    assign id_busy = id_valid & (id_err | swi | is_muldiv(alu_op));
    assign br_ev   = run & ex_br_taken;
    assign ill_ev  = run & ~ex_br_taken & id_valid & id_err;
    assign swi_ev  = run & ~ex_br_taken & id_valid & ~id_err & swi;
    assign md_ev   = run & ~ex_br_taken & id_valid & ~id_err & ~swi & is_muldiv(alu_op);
    assign haz_ev  = run & ~ex_br_taken & ~id_busy & hazard;

    assign ex_hold  = (state == I2D_PCTRL_MD_WAIT);
    assign if_stall = ex_hold | haz_ev;
    assign id_stall = ex_hold | haz_ev;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= I2D_PCTRL_RUN;
            md_cnt      <= 4'd0;
            id_dis      <= 1'b0;
            pc_load     <= 1'b0;
            pc_next     <= 32'd0;
            epc         <= 32'd0;
            exc_cause   <= I2D_EXC_NONE;
            exc_pending <= 1'b0;
        end else begin
            pc_load <= 1'b0;
            id_dis  <= 1'b0;
            // A new exception below overrides this clear in the same cycle.
            if (exc_ack)
                exc_pending <= 1'b0;

            case (state)
                I2D_PCTRL_RUN: begin
                    if (br_ev) begin
                        pc_load <= 1'b1;
                        pc_next <= ex_target;
                        id_dis  <= 1'b1;
                        state   <= I2D_PCTRL_FLUSH;
                    end else if (ill_ev || swi_ev) begin
                        epc         <= id_pc;
                        exc_cause   <= ill_ev ? I2D_EXC_ILL : I2D_EXC_SWI;
                        exc_pending <= 1'b1;
                        pc_load     <= 1'b1;
                        pc_next     <= ill_ev ? VEC_ILL : VEC_SWI;
                        id_dis      <= 1'b1;
                        state       <= I2D_PCTRL_FLUSH;
                    end else if (md_ev) begin
                        // The op itself issues now; holds cover the remaining cycles.
                        md_cnt <= 4'(MD_CYCLES - 1);
                        state  <= I2D_PCTRL_MD_WAIT;
                    end else if (haz_ev) begin
                        id_dis <= 1'b1;
                    end
                end
                // Second bubble after a redirect; whatever EX reports is itself a bubble.
                I2D_PCTRL_FLUSH: begin
                    id_dis <= 1'b1;
                    state  <= I2D_PCTRL_RUN;
                end
                I2D_PCTRL_MD_WAIT: begin
                    md_cnt <= md_cnt - 4'd1;
                    if (md_cnt == 4'd1)
                        state <= I2D_PCTRL_RUN;
                end
                default: state <= I2D_PCTRL_RUN;
            endcase
        end
    end

endmodule

// File: tb/tb_i2d_pipe_ctrl.sv
module tb_i2d_pipe_ctrl;
    import i2d_pipe_ctrl_pkg::*;

    localparam int          MD_CYCLES = 4;
    localparam logic [31:0] VEC_ILL   = 32'h0000_0004;
    localparam logic [31:0] VEC_SWI   = 32'h0000_0008;

    logic        clk = 1'b0;
    logic        rst;
    logic [3:0]  alu_op;
    logic        id_valid, id_err, swi;
    logic [31:0] id_pc;
    logic [3:0]  rfa_addr, rfb_addr;
    logic        rfa_r, rfb_r;
    logic        ex_ld;
    logic [3:0]  ex_wr_addr;
    logic        ex_br_taken;
    logic [31:0] ex_target;
    logic        exc_ack;
    logic        if_stall, id_stall, ex_hold, id_dis, pc_load, exc_pending;
    logic [31:0] pc_next, epc;
    logic [1:0]  exc_cause;

    int n_chk  = 0;
    int n_fail = 0;

    i2d_pipe_ctrl #(.MD_CYCLES(MD_CYCLES), .VEC_ILL(VEC_ILL), .VEC_SWI(VEC_SWI)) dut (
        .clk(clk), .rst(rst), .alu_op(alu_op), .id_valid(id_valid), .id_err(id_err),
        .swi(swi), .id_pc(id_pc), .rfa_addr(rfa_addr), .rfb_addr(rfb_addr),
        .rfa_r(rfa_r), .rfb_r(rfb_r), .ex_ld(ex_ld), .ex_wr_addr(ex_wr_addr),
        .ex_br_taken(ex_br_taken), .ex_target(ex_target), .exc_ack(exc_ack),
        .if_stall(if_stall), .id_stall(id_stall), .ex_hold(ex_hold), .id_dis(id_dis),
        .pc_load(pc_load), .pc_next(pc_next), .epc(epc), .exc_cause(exc_cause),
        .exc_pending(exc_pending)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [3:0]  alu_op;
        logic        id_valid;
        logic        id_err;
        logic        swi;
        logic [31:0] id_pc;
        logic [3:0]  rfa_addr;
        logic [3:0]  rfb_addr;
        logic        rfa_r;
        logic        rfb_r;
        logic        ex_ld;
        logic [3:0]  ex_wr_addr;
        logic        ex_br_taken;
        logic [31:0] ex_target;
        logic        e_stall;
        logic        e_pc_load;
        logic [31:0] e_pc_next;
        logic [31:0] e_epc;
        logic [1:0]  e_cause;
        logic        e_pend;
        logic        e_dis;
    } vec_t;

    vec_t vecs[12];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        alu_op = I2D_ALUOP_ADD; id_valid = 1'b0; id_err = 1'b0; swi = 1'b0;
        id_pc = 32'd0; rfa_addr = 4'd0; rfb_addr = 4'd0; rfa_r = 1'b0; rfb_r = 1'b0;
        ex_ld = 1'b0; ex_wr_addr = 4'd0; ex_br_taken = 1'b0; ex_target = 32'd0;
        exc_ack = 1'b0;
    endtask

    task automatic do_reset();
        idle();
        rst = 1'b1;
        tick();
        rst = 1'b0;
    endtask

    task automatic apply_vec(input int i, input vec_t v);
        do_reset();
        alu_op = v.alu_op; id_valid = v.id_valid; id_err = v.id_err; swi = v.swi;
        id_pc = v.id_pc; rfa_addr = v.rfa_addr; rfb_addr = v.rfb_addr;
        rfa_r = v.rfa_r; rfb_r = v.rfb_r; ex_ld = v.ex_ld; ex_wr_addr = v.ex_wr_addr;
        ex_br_taken = v.ex_br_taken; ex_target = v.ex_target;
        @(negedge clk);
        chk($sformatf("vec%0d if_stall", i), 32'(if_stall), 32'(v.e_stall));
        chk($sformatf("vec%0d id_stall", i), 32'(id_stall), 32'(v.e_stall));
        tick();
        idle();
        chk($sformatf("vec%0d pc_load", i), 32'(pc_load), 32'(v.e_pc_load));
        chk($sformatf("vec%0d pc_next", i), pc_next, v.e_pc_next);
        chk($sformatf("vec%0d epc", i), epc, v.e_epc);
        chk($sformatf("vec%0d exc_cause", i), 32'(exc_cause), 32'(v.e_cause));
        chk($sformatf("vec%0d exc_pending", i), 32'(exc_pending), 32'(v.e_pend));
        chk($sformatf("vec%0d id_dis", i), 32'(id_dis), 32'(v.e_dis));
    endtask

    // Reference model: counts of remaining ignore/hold/bubble cycles.
    int          m_ignore, m_hold, m_dis, ev;
    logic [31:0] m_pc_next, m_epc;
    logic [1:0]  m_cause;
    logic        m_pend, m_load, m_haz;

    initial begin
        int holds;
        logic seen_drop;
        rst = 1'b1;
        idle();
        #1;
        chk("reset if_stall", 32'(if_stall), 0);
        chk("reset ex_hold", 32'(ex_hold), 0);
        chk("reset pc_load", 32'(pc_load), 0);
        chk("reset pc_next", pc_next, 0);
        chk("reset epc", epc, 0);
        chk("reset exc_cause", 32'(exc_cause), 0);
        chk("reset exc_pending", 32'(exc_pending), 0);
        chk("reset id_dis", 32'(id_dis), 0);
        tick();
        rst = 1'b0;

        //           op          v  e  s  id_pc    ra    rb    ar  br  ld  wr    bt  target     st ld pc_next   epc      cause pnd dis
        vecs[0]  = '{I2D_ALUOP_ADD, 0, 0, 0, 32'h0,   4'd0, 4'd0, 0, 0, 0, 4'd0, 0, 32'h0,     0, 0, 32'h0,    32'h0,  2'b00, 0, 0};
        vecs[1]  = '{I2D_ALUOP_ADD, 1, 0, 0, 32'h10,  4'd1, 4'd2, 1, 1, 0, 4'd1, 0, 32'h0,     0, 0, 32'h0,    32'h0,  2'b00, 0, 0};
        vecs[2]  = '{I2D_ALUOP_ADD, 1, 0, 0, 32'h10,  4'd5, 4'd0, 1, 0, 1, 4'd5, 0, 32'h0,     1, 0, 32'h0,    32'h0,  2'b00, 0, 1};
        vecs[3]  = '{I2D_ALUOP_ADD, 1, 0, 0, 32'h10,  4'd6, 4'd0, 1, 0, 1, 4'd5, 0, 32'h0,     0, 0, 32'h0,    32'h0,  2'b00, 0, 0};
        vecs[4]  = '{I2D_ALUOP_SUB, 1, 0, 0, 32'h10,  4'd3, 4'd9, 1, 1, 1, 4'd9, 0, 32'h0,     1, 0, 32'h0,    32'h0,  2'b00, 0, 1};
        vecs[5]  = '{I2D_ALUOP_ADD, 1, 0, 0, 32'h10,  4'd7, 4'd7, 0, 0, 1, 4'd7, 0, 32'h0,     0, 0, 32'h0,    32'h0,  2'b00, 0, 0};
        vecs[6]  = '{I2D_ALUOP_ADD, 1, 1, 0, 32'h30,  4'd0, 4'd0, 0, 0, 0, 4'd0, 1, 32'h100,   0, 1, 32'h100,  32'h0,  2'b00, 0, 1};
        vecs[7]  = '{I2D_ALUOP_ADD, 1, 1, 0, 32'h20,  4'd0, 4'd0, 0, 0, 0, 4'd0, 0, 32'h0,     0, 1, VEC_ILL,  32'h20, 2'b01, 1, 1};
        vecs[8]  = '{I2D_ALUOP_ADD, 1, 0, 1, 32'h40,  4'd0, 4'd0, 0, 0, 0, 4'd0, 0, 32'h0,     0, 1, VEC_SWI,  32'h40, 2'b10, 1, 1};
        vecs[9]  = '{I2D_ALUOP_ADD, 0, 1, 0, 32'h44,  4'd0, 4'd0, 0, 0, 0, 4'd0, 0, 32'h0,     0, 0, 32'h0,    32'h0,  2'b00, 0, 0};
        vecs[10] = '{I2D_ALUOP_ADD, 1, 1, 1, 32'h50,  4'd0, 4'd0, 0, 0, 0, 4'd0, 0, 32'h0,     0, 1, VEC_ILL,  32'h50, 2'b01, 1, 1};
        vecs[11] = '{I2D_ALUOP_ADD, 1, 0, 1, 32'h60,  4'd0, 4'd0, 0, 0, 0, 4'd0, 1, 32'h200,   0, 1, 32'h200,  32'h0,  2'b00, 0, 1};
        for (int i = 0; i < 12; i++) apply_vec(i, vecs[i]);

        // MUL occupancy: holds for MD_CYCLES-1 cycles, then the next ADD issues.
        do_reset();
        alu_op = I2D_ALUOP_MUL; id_valid = 1'b1;
        @(negedge clk);
        chk("mul issue no stall", 32'(if_stall), 0);
        tick();
        alu_op = I2D_ALUOP_ADD;
        holds = 0;
        seen_drop = 1'b0;
        for (int c = 0; c < 8; c++) begin
            @(negedge clk);
            if (ex_hold && !seen_drop) holds++;
            if (!ex_hold) seen_drop = 1'b1;
            if (ex_hold && seen_drop) chk("mul hold re-asserted", 1, 0);
            if ((if_stall !== ex_hold) || (id_stall !== ex_hold))
                chk("mul stalls track hold", {if_stall, id_stall}, {ex_hold, ex_hold});
        end
        chk("mul hold cycles", holds, MD_CYCLES - 1);
        chk("add after mul no stall", 32'(if_stall), 0);
        chk("add after mul no bubble", 32'(id_dis), 0);

        // Reset asserted mid-MD_WAIT.
        do_reset();
        alu_op = I2D_ALUOP_MUL; id_valid = 1'b1;
        tick();
        alu_op = I2D_ALUOP_ADD;
        tick();
        chk("pre-reset ex_hold", 32'(ex_hold), 1);
        rst = 1'b1;
        #1;
        chk("mid-md reset ex_hold", 32'(ex_hold), 0);
        chk("mid-md reset if_stall", 32'(if_stall), 0);
        chk("mid-md reset id_stall", 32'(id_stall), 0);
        tick();
        rst = 1'b0;
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            chk($sformatf("post-reset run stall c%0d", c), {if_stall, ex_hold}, 0);
        end

        // Redirect: ex_br_taken held into FLUSH must be ignored; two bubbles.
        do_reset();
        ex_br_taken = 1'b1; ex_target = 32'h100; id_valid = 1'b1; id_err = 1'b1;
        tick();
        ex_target = 32'h999; id_err = 1'b0;
        chk("br pc_load", 32'(pc_load), 1);
        chk("br id_dis t1", 32'(id_dis), 1);
        tick();
        idle();
        chk("flush pc_load", 32'(pc_load), 0);
        chk("flush pc_next held", pc_next, 32'h100);
        chk("flush id_dis t2", 32'(id_dis), 1);
        chk("br exc_cause", 32'(exc_cause), 0);
        tick();
        chk("br id_dis t3", 32'(id_dis), 0);

        // SWI capture, then exc_ack clears pending but keeps epc.
        do_reset();
        swi = 1'b1; id_valid = 1'b1; id_pc = 32'h40;
        tick();
        idle();
        tick();
        tick();
        exc_ack = 1'b1;
        tick();
        exc_ack = 1'b0;
        chk("ack exc_pending", 32'(exc_pending), 0);
        chk("ack epc kept", epc, 32'h40);
        chk("ack pc_next kept", pc_next, VEC_SWI);

        // Load-use: one stall, then one bubble once the load has moved on.
        do_reset();
        ex_ld = 1'b1; ex_wr_addr = 4'd5; rfa_r = 1'b1; rfa_addr = 4'd5; id_valid = 1'b1;
        @(negedge clk);
        chk("lu stall", 32'(if_stall), 1);
        tick();
        ex_ld = 1'b0;
        chk("lu bubble", 32'(id_dis), 1);
        @(negedge clk);
        chk("lu no second stall", 32'(if_stall), 0);
        tick();
        chk("lu single bubble", 32'(id_dis), 0);

        // Randomised run against the reference model.
        do_reset();
        m_ignore = 0; m_hold = 0; m_dis = 0;
        m_pc_next = 0; m_epc = 0; m_cause = 0; m_pend = 0;
        for (int c = 0; c < 600; c++) begin
            alu_op      = 4'($urandom_range(0, 15));
            id_valid    = ($urandom_range(0, 3) != 0);
            id_err      = ($urandom_range(0, 9) == 0);
            swi         = ($urandom_range(0, 9) == 0);
            id_pc       = $urandom;
            rfa_addr    = 4'($urandom_range(0, 3));
            rfb_addr    = 4'($urandom_range(0, 3));
            rfa_r       = 1'($urandom_range(0, 1));
            rfb_r       = 1'($urandom_range(0, 1));
            ex_ld       = ($urandom_range(0, 2) == 0);
            ex_wr_addr  = 4'($urandom_range(0, 3));
            ex_br_taken = ($urandom_range(0, 9) == 0);
            ex_target   = $urandom;
            exc_ack     = ($urandom_range(0, 7) == 0);
            @(negedge clk);
            m_haz = ex_ld && ((rfa_r && rfa_addr == ex_wr_addr) || (rfb_r && rfb_addr == ex_wr_addr));
            ev = 0;
            if (m_ignore == 0) begin
                if (ex_br_taken) ev = 1;
                else if (id_valid && id_err) ev = 2;
                else if (id_valid && swi) ev = 3;
                else if (id_valid && alu_op inside {I2D_ALUOP_MUL, I2D_ALUOP_MULU,
                                                    I2D_ALUOP_DIV, I2D_ALUOP_DIVU}) ev = 4;
                else if (m_haz) ev = 5;
            end
            chk($sformatf("rnd%0d ex_hold", c), 32'(ex_hold), 32'(m_hold > 0));
            chk($sformatf("rnd%0d if_stall", c), 32'(if_stall), 32'((m_hold > 0) || ev == 5));
            chk($sformatf("rnd%0d id_stall", c), 32'(id_stall), 32'((m_hold > 0) || ev == 5));
            tick();
            if (m_ignore > 0) m_ignore--;
            if (m_hold > 0) m_hold--;
            if (exc_ack) m_pend = 1'b0;
            m_load = (ev >= 1 && ev <= 3);
            case (ev)
                1: begin m_pc_next = ex_target; m_dis = 2; m_ignore = 1; end
                2: begin m_epc = id_pc; m_cause = I2D_EXC_ILL; m_pend = 1'b1;
                         m_pc_next = VEC_ILL; m_dis = 2; m_ignore = 1; end
                3: begin m_epc = id_pc; m_cause = I2D_EXC_SWI; m_pend = 1'b1;
                         m_pc_next = VEC_SWI; m_dis = 2; m_ignore = 1; end
                4: begin m_hold = MD_CYCLES - 1; m_ignore = MD_CYCLES - 1; end
                5: m_dis = 1;
                default: ;
            endcase
            chk($sformatf("rnd%0d id_dis", c), 32'(id_dis), 32'(m_dis > 0));
            if (m_dis > 0) m_dis--;
            chk($sformatf("rnd%0d pc_load", c), 32'(pc_load), 32'(m_load));
            chk($sformatf("rnd%0d pc_next", c), pc_next, m_pc_next);
            chk($sformatf("rnd%0d epc", c), epc, m_epc);
            chk($sformatf("rnd%0d exc_cause", c), 32'(exc_cause), 32'(m_cause));
            chk($sformatf("rnd%0d exc_pending", c), 32'(exc_pending), 32'(m_pend));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
